input_vc_unit: RTL
==================

# input_vc_unit

Parametrised router input port with per-virtual-channel flit buffering, a per-VC route/switch FSM, selectable XY/YX dimension-order routing and credit return. Sits between an upstream link and the router's switch allocator; one instance per router input port. Successor of the single-channel input unit: adds NUM_VCS independent channels, buffering, round-robin switch requests, credits and protocol-error handling.

## Interface

Parameters:
- NUM_VCS, 2: virtual channels per port (1..8); VC_W = max(1, clog2(NUM_VCS)).
- BUF_DEPTH, 4: flit slots per VC (power of 2, ≥2).
- ADDR_W, 4: width of each of xaddr and yaddr.
- FLIT_W, 32: flit width (≥ 2*ADDR_W+3).
- X_ADDR, 0 / Y_ADDR, 0: this router's coordinates.
- ROUTE_MODE, 0: 0 = XY (resolve x first), 1 = YX.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- i_flit_valid  in  1  flit present on link
- i_flit  in  FLIT_W  [FLIT_W-1:FLIT_W-2] type (00 HEAD_TAIL, 01 HEAD, 10 BODY, 11 TAIL); head: [ADDR_W-1:0] xaddr, [2*ADDR_W-1:ADDR_W] yaddr
- i_flit_vc  in  VC_W  target VC
- o_switch_req  out  1  request to switch allocator
- o_req_port  out  3  output port: 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST
- o_req_vc  out  VC_W  requesting VC
- i_switch_ack  in  1  grant for the current request, same cycle
- o_flit_valid  out  1  flit to crossbar
- o_flit  out  FLIT_W  forwarded flit
- o_flit_vc  out  VC_W  VC of forwarded flit
- o_credit_valid  out  1  one slot freed
- o_credit_vc  out  VC_W  VC of freed slot
- o_packet_done  out  1  tail (or HEAD_TAIL) forwarded
- o_proto_err  out  1  pulse: non-head flit at head of IDLE VC
- o_overflow  out  1  sticky: write to full VC

## Operation

- Per-VC FIFO of BUF_DEPTH. Write when i_flit_valid into VC i_flit_vc; accepted if not full or popped same cycle; else dropped and o_overflow set (cleared only by reset).
- Per-VC FSM, states IDLE, ROUTING, ACTIVE:
  - IDLE, FIFO empty: stay. Head is HEAD/HEAD_TAIL: -> ROUTING. Head is BODY/TAIL: pop and discard, pulse o_proto_err, return credit, stay IDLE.
  - ROUTING: compute port from head flit, register per-VC route, -> ACTIVE (exactly one cycle).
  - ACTIVE: eligible for switch when FIFO non-empty. On ack, pop head; if popped type TAIL or HEAD_TAIL -> IDLE and pulse o_packet_done.
- Routing, XY: x==X_ADDR and y==Y_ADDR -> LOCAL; x>X_ADDR EAST; x<X_ADDR WEST; else y<Y_ADDR NORTH; y>Y_ADDR SOUTH. YX: y compared first, then x. Unsigned compares.
- Switch request: round-robin over eligible VCs starting at pointer; o_switch_req=1 with winner's o_req_port/o_req_vc. Pointer moves to winner+1 (mod NUM_VCS) only on i_switch_ack; held otherwise. Request combinational from registered state.
- o_proto_err discard and o_credit for it share the credit path; a forwarded flit and a discard in same cycle on different VCs: forwarded credit this cycle, discard deferred (discard only when no ack that cycle).

## Timing

- Reset: all FSMs IDLE, FIFOs empty, RR pointer 0, all outputs 0.
- Write at edge t -> flit at head from t+1; IDLE->ROUTING at t+1, ACTIVE at t+2, first o_switch_req cycle t+2 (head latency 2 cycles after write).
- Ack in cycle c -> o_flit_valid/o_flit/o_flit_vc and o_credit_valid/o_credit_vc registered, asserted in c+1 for one cycle; o_packet_done in c+1.
- Back-to-back: ACTIVE VC with continuous acks forwards one flit per cycle.
- New packet head behind a tail in same FIFO: ROUTING starts the cycle after tail popped.
- Reset mid-packet: all state discarded, no credits emitted.

## Test plan

- XY, X_ADDR=1,Y_ADDR=1: HEAD_TAIL to (3,0) on VC0 -> req port EAST from cycle 2, ack -> o_flit_valid, o_credit_vc=0, o_packet_done next cycle.
- YX same router/destination -> port NORTH; destination (1,1) -> LOCAL in both modes.
- Two 3-flit packets on VC0 (to WEST) and VC1 (to SOUTH), ack always 1 -> flits interleave VC0,VC1,VC0,...; two packet_done pulses; 6 credits.
- Ack held 0 for 5 cycles with BUF_DEPTH=4: 5th write to full VC -> o_overflow=1, sticky; request, port and vc held stable.
- BODY flit into idle VC1 -> o_proto_err pulse, credit on VC1, no o_flit_valid, VC stays IDLE.
- reset_n low mid-packet -> all outputs 0 asynchronously; next HEAD routed normally.

Source files
------------

// File: rtl/input_vc_unit.sv
// Router input port: per-VC flit FIFOs, route/switch FSM per VC,
// round-robin switch requests, credit return and protocol checks.
module input_vc_unit #(
    parameter int NUM_VCS    = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int ADDR_W     = 4,
    parameter int FLIT_W     = 32,
    parameter int X_ADDR     = 0,
    parameter int Y_ADDR     = 0,
    parameter int ROUTE_MODE = 0,
    localparam int VC_W      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_flit_valid,
    input  logic [FLIT_W-1:0] i_flit,
    input  logic [VC_W-1:0]   i_flit_vc,
    output logic              o_switch_req,
    output logic [2:0]        o_req_port,
    output logic [VC_W-1:0]   o_req_vc,
    input  logic              i_switch_ack,
    output logic              o_flit_valid,
    output logic [FLIT_W-1:0] o_flit,
    output logic [VC_W-1:0]   o_flit_vc,
    output logic              o_credit_valid,
    output logic [VC_W-1:0]   o_credit_vc,
    output logic              o_packet_done,
    output logic              o_proto_err,
    output logic              o_overflow
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [ADDR_W-1:0] XA = ADDR_W'(X_ADDR);
    localparam logic [ADDR_W-1:0] YA = ADDR_W'(Y_ADDR);
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUTING,
        S_ACTIVE
    } vc_state_e;

    vc_state_e          state_q [NUM_VCS];
    vc_state_e          state_d [NUM_VCS];
    logic [2:0]         route_q [NUM_VCS];
    logic [2:0]         route_d [NUM_VCS];
    logic [PW-1:0]      rd_q    [NUM_VCS];
    logic [PW-1:0]      rd_d    [NUM_VCS];
    logic [PW-1:0]      wr_q    [NUM_VCS];
    logic [PW-1:0]      wr_d    [NUM_VCS];
    logic [FLIT_W-1:0]  mem_q   [NUM_VCS][BUF_DEPTH];
    logic [FLIT_W-1:0]  head    [NUM_VCS];

    logic [NUM_VCS-1:0] empty;
    logic [NUM_VCS-1:0] full;
    logic [NUM_VCS-1:0] elig;
    logic [NUM_VCS-1:0] bad_head;
    logic [NUM_VCS-1:0] pop;
    logic [NUM_VCS-1:0] push;

    logic [VC_W-1:0]    rr_q, rr_d;
    logic [VC_W-1:0]    win_vc, disc_vc;
    logic               found, grant, disc;

    logic               flit_valid_q, flit_valid_d;
    logic [FLIT_W-1:0]  flit_q, flit_d;
    logic [VC_W-1:0]    flit_vc_q, flit_vc_d;
    logic               credit_valid_q, credit_valid_d;
    logic [VC_W-1:0]    credit_vc_q, credit_vc_d;
    logic               done_q, done_d;
    logic               perr_q, perr_d;
    logic               ovf_q, ovf_d;

    function automatic logic is_tail(input logic [FLIT_W-1:0] f);
        return f[FLIT_W-1] == f[FLIT_W-2];
    endfunction

    // Magnitude compares via borrow bit, so constant coordinates of 0 stay clean.
    function automatic logic [2:0] route_of(
        input logic [ADDR_W-1:0] x,
        input logic [ADDR_W-1:0] y
    );
        logic [ADDR_W:0] dx, dy;
        logic            x_lt, y_lt, x_eq, y_eq;
        logic [2:0]      p;
        dx   = {1'b0, x} - {1'b0, XA};
        dy   = {1'b0, y} - {1'b0, YA};
        x_lt = dx[ADDR_W];
        y_lt = dy[ADDR_W];
        x_eq = (x == XA);
        y_eq = (y == YA);
        if (x_eq && y_eq) begin
            p = P_LOCAL;
        end else if (ROUTE_MODE == 0) begin
            if (!x_eq)     p = x_lt ? P_WEST : P_EAST;
            else           p = y_lt ? P_NORTH : P_SOUTH;
        end else begin
            if (!y_eq)     p = y_lt ? P_NORTH : P_SOUTH;
            else           p = x_lt ? P_WEST : P_EAST;
        end
        return p;
    endfunction

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            head[v]     = mem_q[v][rd_q[v][AW-1:0]];
            empty[v]    = (rd_q[v] == wr_q[v]);
            full[v]     = ((wr_q[v] - rd_q[v]) == PW'(BUF_DEPTH));
            elig[v]     = (state_q[v] == S_ACTIVE) && !empty[v];
            bad_head[v] = (state_q[v] == S_IDLE) && !empty[v]
                          && head[v][FLIT_W-1];
        end
    end

    always_comb begin
        found  = 1'b0;
        win_vc = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            if (!found && elig[(int'(rr_q) + k) % NUM_VCS]) begin
                found  = 1'b1;
                win_vc = VC_W'((int'(rr_q) + k) % NUM_VCS);
            end
        end
        grant = found && i_switch_ack;
    end

    // Discards share the credit path, so they wait for a cycle without a grant.
    always_comb begin
        disc    = 1'b0;
        disc_vc = '0;
        for (int v = NUM_VCS - 1; v >= 0; v--) begin
            if (bad_head[v] && !grant) begin
                disc    = 1'b1;
                disc_vc = VC_W'(v);
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            pop[v]  = (grant && win_vc == VC_W'(v))
                      || (disc && disc_vc == VC_W'(v));
            push[v] = i_flit_valid && (i_flit_vc == VC_W'(v))
                      && (!full[v] || pop[v]);
            if (i_flit_valid && i_flit_vc == VC_W'(v) && full[v] && !pop[v])
                ovf_d = 1'b1;
            rd_d[v] = rd_q[v] + PW'(pop[v]);
            wr_d[v] = wr_q[v] + PW'(push[v]);
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            state_d[v] = state_q[v];
            route_d[v] = route_q[v];
            unique case (state_q[v])
                S_IDLE: begin
                    if (!empty[v] && !head[v][FLIT_W-1])
                        state_d[v] = S_ROUTING;
                end
                S_ROUTING: begin
                    route_d[v] = route_of(head[v][ADDR_W-1:0],
                                          head[v][2*ADDR_W-1:ADDR_W]);
                    state_d[v] = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (grant && win_vc == VC_W'(v) && is_tail(head[v]))
                        state_d[v] = S_IDLE;
                end
                default: state_d[v] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        flit_valid_d   = grant;
        flit_d         = grant ? head[win_vc] : '0;
        flit_vc_d      = grant ? win_vc : '0;
        credit_valid_d = grant || disc;
        credit_vc_d    = grant ? win_vc : (disc ? disc_vc : '0);
        done_d         = grant && is_tail(head[win_vc]);
        perr_d         = disc;
        rr_d           = grant ? VC_W'((int'(win_vc) + 1) % NUM_VCS) : rr_q;
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if (push[v])
                mem_q[v][wr_q[v][AW-1:0]] <= i_flit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                state_q[v] <= S_IDLE;
                route_q[v] <= '0;
                rd_q[v]    <= '0;
                wr_q[v]    <= '0;
            end
            rr_q           <= '0;
            flit_valid_q   <= 1'b0;
            flit_q         <= '0;
            flit_vc_q      <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            done_q         <= 1'b0;
            perr_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                state_q[v] <= state_d[v];
                route_q[v] <= route_d[v];
                rd_q[v]    <= rd_d[v];
                wr_q[v]    <= wr_d[v];
            end
            rr_q           <= rr_d;
            flit_valid_q   <= flit_valid_d;
            flit_q         <= flit_d;
            flit_vc_q      <= flit_vc_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            done_q         <= done_d;
            perr_q         <= perr_d;
            ovf_q          <= ovf_d;
        end
    end

    assign o_switch_req   = found;
    assign o_req_port     = found ? route_q[win_vc] : 3'd0;
    assign o_req_vc       = win_vc;
    assign o_flit_valid   = flit_valid_q;
    assign o_flit         = flit_q;
    assign o_flit_vc      = flit_vc_q;
    assign o_credit_valid = credit_valid_q;
    assign o_credit_vc    = credit_vc_q;
    assign o_packet_done  = done_q;
    assign o_proto_err    = perr_q;
    assign o_overflow     = ovf_q;

endmodule
